// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_req_arbiter
//  Description : Round-robin arbiter that shares one apb_master command port
//                between NUM_REQ requesters. It supports an optional
//                per-requester lock for back-to-back bursts. It captures the
//                winner's command, runs one transfer, returns the read data
//                and pulses done for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_vec,
    input  logic [NUM_REQ-1:0]        write_vec,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_vec,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_vec,
    input  logic [NUM_REQ-1:0]        lock_vec,
    output logic [NUM_REQ-1:0]        gnt_vec,
    output logic [NUM_REQ-1:0]        done_vec,
    output logic [DATA_W-1:0]         rdata_out,
    output logic                      busy,
    output logic                      m_req,
    output logic                      m_write,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_ready
);

    localparam int                 c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] c_ONE   = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_PTR_W-1:0]   r_winner;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_m_req;
    logic                 r_m_write;
    logic [ADDR_W-1:0]    r_m_addr;
    logic [DATA_W-1:0]    r_m_wdata;

    logic [c_PTR_W-1:0]   w_winner;
    logic [c_PTR_W-1:0]   w_ptr_nxt;
    logic                 w_grant;
    logic                 w_finish;

    // Requester index `step` positions after p, wrapping modulo NUM_REQ.
    function automatic logic [c_PTR_W-1:0] wrap_inc(input logic [c_PTR_W-1:0] p, input int step);
        int s;
        s = (int'(p) + step) % NUM_REQ;
        return c_PTR_W'(s);
    endfunction

    // Round-robin pick: scan from the far end so the request nearest rr_ptr is written last and wins.
    always_comb begin
        w_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_vec[wrap_inc(r_rr_ptr, k)]) begin
                w_winner = wrap_inc(r_rr_ptr, k);
            end
        end
    end

    // A locked winner keeps first priority; otherwise priority moves to its neighbour.
    assign w_ptr_nxt = lock_vec[r_winner] ? r_winner : wrap_inc(r_winner, 1);

    // Next-state logic plus the grant/finish strobes that steer the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req_vec) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (m_ready) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command capture at grant; completion, read data and pointer update at the end of the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_winner  <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_m_req   <= 1'b0;
            r_m_write <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else begin
            r_done <= '0;
            if (w_grant) begin
                r_winner  <= w_winner;
                r_gnt     <= c_ONE << w_winner;
                r_m_req   <= 1'b1;
                r_m_write <= write_vec[w_winner];
                r_m_addr  <= addr_vec[int'(w_winner) * ADDR_W +: ADDR_W];
                r_m_wdata <= wdata_vec[int'(w_winner) * DATA_W +: DATA_W];
            end
            if (w_finish) begin
                r_m_req  <= 1'b0;
                r_done   <= r_gnt;
                r_gnt    <= '0;
                r_rr_ptr <= w_ptr_nxt;
                if (!r_m_write) begin
                    r_rdata <= m_rdata;
                end
            end
        end
    end

    assign gnt_vec   = r_gnt;
    assign done_vec  = r_done;
    assign rdata_out = r_rdata;
    assign busy      = (r_state != ST_IDLE);
    assign m_req     = r_m_req;
    assign m_write   = r_m_write;
    assign m_addr    = r_m_addr;
    assign m_wdata   = r_m_wdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_req_arbiter
//  Description : Self-checking bench for apb_req_arbiter. It contains an APB
//                slave stand-in, a priority-list reference model, a per-cycle
//                compare and directed scenarios with literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic [N-1:0]      req_vec   = '0;
    logic [N-1:0]      write_vec = '0;
    logic [N-1:0]      lock_vec  = '0;
    logic [N*AW-1:0]   addr_vec  = '0;
    logic [N*DW-1:0]   wdata_vec = '0;
    logic [N-1:0]      gnt_vec;
    logic [N-1:0]      done_vec;
    logic [DW-1:0]     rdata_out;
    logic              busy;
    logic              m_req;
    logic              m_write;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [DW-1:0]     m_rdata   = '0;
    logic              m_ready   = 1'b0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    apb_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req_vec(req_vec), .write_vec(write_vec),
        .addr_vec(addr_vec), .wdata_vec(wdata_vec), .lock_vec(lock_vec),
        .gnt_vec(gnt_vec), .done_vec(done_vec), .rdata_out(rdata_out),
        .busy(busy), .m_req(m_req), .m_write(m_write), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out", nm);
    endtask

    // ---------------- APB slave stand-in ----------------
    logic [DW-1:0] mem [64];
    int slave_lat  = 1;
    int extra_hold = 0;
    int s_cnt      = 0;
    int s_hold     = 0;

    function automatic logic [DW-1:0] slave_read(input logic [AW-1:0] a);
        if (a >= 32'h100) return 32'hBAD0_0000 | a;
        return mem[a[7:2]];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_ready = 1'b0;
            s_cnt   = 0;
            s_hold  = 0;
        end else if (s_hold > 0) begin
            s_hold--;
        end else if (m_ready) begin
            m_ready = 1'b0;
        end else if (m_req) begin
            if (s_cnt >= slave_lat) begin
                m_ready = 1'b1;
                s_hold  = extra_hold;
                s_cnt   = 0;
                if (m_write) begin
                    if (m_addr < 32'h100) mem[m_addr[7:2]] = m_wdata;
                    m_rdata = '0;
                end else begin
                    m_rdata = slave_read(m_addr);
                end
            end else begin
                s_cnt++;
            end
        end else begin
            s_cnt = 0;
        end
    end

    // ---------------- Reference model: ordered priority list ----------------
    int           e_order [N];
    int           e_phase;     // 0 waiting, 1 transfer in flight, 2 one-cycle pause
    int           e_win;
    logic [N-1:0] e_gnt, e_done;
    logic [DW-1:0] e_rdata, e_mwdata;
    logic [AW-1:0] e_maddr;
    logic         e_mreq, e_mwrite;

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) if (r[e_order[k]]) return e_order[k];
        return 0;
    endfunction

    function automatic int next_head(input int w, input logic lk);
        return lk ? w : (w + 1) % N;
    endfunction

    // Model advances on the same edge as the DUT, from the same sampled inputs.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) e_order[i] <= i;
            e_phase <= 0; e_win <= 0; e_gnt <= '0; e_done <= '0; e_rdata <= '0;
            e_mreq <= 1'b0; e_mwrite <= 1'b0; e_maddr <= '0; e_mwdata <= '0;
        end else begin
            e_done <= '0;
            if (e_phase == 0) begin
                if (req_vec != 0) begin
                    e_win    <= pick(req_vec);
                    e_gnt    <= 4'b0001 << pick(req_vec);
                    e_mreq   <= 1'b1;
                    e_mwrite <= write_vec[pick(req_vec)];
                    e_maddr  <= addr_vec[pick(req_vec)*AW +: AW];
                    e_mwdata <= wdata_vec[pick(req_vec)*DW +: DW];
                    e_phase  <= 1;
                end
            end else if (e_phase == 1) begin
                if (m_ready) begin
                    e_mreq <= 1'b0;
                    if (!e_mwrite) e_rdata <= m_rdata;
                    e_done <= e_gnt;
                    e_gnt  <= '0;
                    for (int i = 0; i < N; i++)
                        e_order[i] <= (next_head(e_win, lock_vec[e_win]) + i) % N;
                    e_phase <= 2;
                end
            end else begin
                e_phase <= 0;
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt_vec", gnt_vec, e_gnt);
            chk("done_vec", done_vec, e_done);
            chk("rdata_out", rdata_out, e_rdata);
            chk("busy", busy, (e_phase != 0));
            chk("m_req", m_req, e_mreq);
            chk("gnt_onehot0", $onehot0(gnt_vec), 1);
            if (e_mreq) begin
                chk("m_write", m_write, e_mwrite);
                chk("m_addr", m_addr, e_maddr);
                chk("m_wdata", m_wdata, e_mwdata);
            end
        end
    end

    // ---------------- Monitor: grant order, done counts, req-low gaps ----------------
    int           glog [$];
    int           done_cnt [N];
    int           done_total = 0;
    int           min_gap = 99;
    int           low_run = 0;
    bit           seen_req = 1'b0;
    logic [N-1:0] prev_gnt = '0;
    logic         prev_mreq = 1'b0;

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int log_code();
        int c = 0;
        foreach (glog[i]) c = c * 16 + glog[i];
        return c;
    endfunction

    always @(posedge clk) begin
        #1;
        if (gnt_vec != 0 && prev_gnt == 0) glog.push_back(oh2i(gnt_vec));
        prev_gnt = gnt_vec;
        for (int i = 0; i < N; i++) if (done_vec[i]) done_cnt[i]++;
        if (done_vec != 0) done_total++;
        if (m_req && !prev_mreq) begin
            if (seen_req && low_run < min_gap) min_gap = low_run;
            seen_req = 1'b1;
        end
        low_run   = m_req ? 0 : low_run + 1;
        prev_mreq = m_req;
    end

    // ---------------- Stimulus helpers ----------------
    task automatic clear_mon();
        glog.delete();
        for (int i = 0; i < N; i++) done_cnt[i] = 0;
        done_total = 0;
        min_gap    = 99;
        seen_req   = 1'b0;
    endtask

    task automatic set_cmd(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_vec[i]           = wr;
        addr_vec[i*AW +: AW]   = a;
        wdata_vec[i*DW +: DW]  = d;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    // Each requester drops its request when it sees its own done pulse.
    task automatic drain(input string nm, input int budget);
        int n = 0;
        while (req_vec != 0 || busy) begin
            @(negedge clk);
            req_vec = req_vec & ~done_vec;
            n++;
            if (n > budget) begin
                timeout(nm);
                req_vec = '0;
                break;
            end
        end
    endtask

    task automatic run_until_done(input string nm, input int target, input int lock_drop_at, input int budget);
        int n = 0;
        while (done_total < target) begin
            @(negedge clk);
            if (lock_drop_at > 0 && glog.size() >= lock_drop_at) lock_vec = '0;
            n++;
            if (n > budget) begin
                timeout(nm);
                break;
            end
        end
        req_vec = '0;
        cyc(3);
    endtask

    task automatic wait_gnt(input string nm, input int budget);
        int n = 0;
        while (gnt_vec == 0) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                timeout(nm);
                break;
            end
        end
    endtask

    // ---------------- Directed scenarios ----------------
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        cyc(3);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_gnt", gnt_vec, 4'b0000);
        chk("rst_m_req", m_req, 0);
        chk("rst_rdata", rdata_out, 0);

        // 1: single write then read-back through requester 1
        clear_mon();
        slave_lat = 1;
        set_cmd(1, 1'b1, 32'h8, 32'hA000_0002);
        req_vec = 4'b0010;
        @(negedge clk);
        chk("t1_gnt", gnt_vec, 4'b0010);
        chk("t1_m_req", m_req, 1);
        chk("t1_m_addr", m_addr, 32'h8);
        chk("t1_m_write", m_write, 1);
        drain("t1_write", 40);
        chk("t1_done_once", done_cnt[1], 1);
        set_cmd(1, 1'b0, 32'h8, 32'h0);
        req_vec = 4'b0010;
        drain("t1_read", 40);
        chk("t1_rdata", rdata_out, 32'hA000_0002);

        // 2: all four read at once after reset: order 0,1,2,3
        do_reset();
        clear_mon();
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 32'(i * 4), 32'h0);
        req_vec = 4'b1111;
        drain("t2", 200);
        chk("t2_order", log_code(), 32'h0123);
        chk("t2_len", glog.size(), 4);
        for (int i = 0; i < N; i++) chk("t2_done_each", done_cnt[i], 1);
        chk("t2_gap_ge2", (min_gap >= 2), 1);
        chk("t2_rdata", rdata_out, 32'h1000_0003);

        // 3: requesters 0 and 2 re-request continuously: alternate for 8 transfers
        do_reset();
        clear_mon();
        req_vec = 4'b0101;
        run_until_done("t3", 8, 0, 400);
        chk("t3_order", log_code(), 32'h0202_0202);
        chk("t3_len", glog.size(), 8);
        chk("t3_gap_ge2", (min_gap >= 2), 1);

        // 4: requesters 1 and 3 continuous, 3 locked until its third grant
        do_reset();
        clear_mon();
        set_cmd(1, 1'b0, 32'h4, 32'h0);
        set_cmd(3, 1'b0, 32'hC, 32'h0);
        lock_vec = 4'b1000;
        req_vec  = 4'b1010;
        run_until_done("t4", 5, 4, 400);
        chk("t4_order", log_code(), 32'h0001_3331);
        chk("t4_len", glog.size(), 5);

        // 5: reset while requester 0 is mid-transfer; rr pointer must restart at 0
        clear_mon();
        slave_lat = 6;
        set_cmd(0, 1'b0, 32'h4, 32'h0);
        req_vec = 4'b0001;
        wait_gnt("t5_first_gnt", 20);
        rst = 1'b1;
        req_vec = 4'b1001;
        @(negedge clk);
        chk("t5_rst_gnt", gnt_vec, 0);
        chk("t5_rst_m_req", m_req, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done_vec, 0);
        chk("t5_rst_rdata", rdata_out, 0);
        chk("t5_rst_m_addr", m_addr, 0);
        rst = 1'b0;
        @(negedge clk);
        wait_gnt("t5_regrant", 20);
        chk("t5_regrant_0", gnt_vec, 4'b0001);
        drain("t5", 200);
        chk("t5_done0_once", done_cnt[0], 1);
        chk("t5_done3_once", done_cnt[3], 1);

        // 6: ready held high 3 cycles on an out-of-range read
        clear_mon();
        slave_lat  = 0;
        extra_hold = 2;
        set_cmd(2, 1'b0, 32'h100, 32'h0);
        req_vec = 4'b0100;
        drain("t6", 40);
        cyc(6);
        chk("t6_done_once", done_cnt[2], 1);
        chk("t6_no_phantom", glog.size(), 1);
        chk("t6_rdata", rdata_out, 32'hBAD0_0100);
        chk("t6_m_req_low", m_req, 0);
        extra_hold = 0;

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
